ppu_seq_ctrl: RTL

//  Sequences one post-processing pass: streams N 32-bit psums from the psum buffer through the PPU
//  (ReLU + divide-by-scale + int8 truncate, 1-cycle latency) and packs the int8 results 4-per-word

---
 rtl/ppu_seq_ctrl_pkg.sv | 20 ++
 rtl/ppu_byte_fifo.sv | 41 ++++
 rtl/ppu_seq_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_seq_ctrl_pkg.sv
// Shared types and constants for the PPU post-processing sequencer.
package ppu_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned SCALE_W        = 12;
  localparam int unsigned WORD_W         = 32;

  // Byte enables for a word holding n valid bytes (n in 1..4).
  function automatic logic [BYTES_PER_WORD-1:0] tail_strb(input logic [2:0] n);
    return 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/ppu_byte_fifo.sv
// Small byte FIFO buffering PPU results ahead of the output packer.
module ppu_byte_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [7:0]       push_data_i,
  input  logic             pop_i,
  output logic [7:0]       head_c_o,
  output logic [CNT_W-1:0] count_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign count_o  = count_q;

endmodule

// File: rtl/ppu_seq_ctrl.sv
// Streams psums through the PPU and packs int8 results 4-per-word into the output GLB.
// Optional PPU_SEQ_CTRL_PERF_EN adds busy-cycle and write-stall counters.
module ppu_seq_ctrl
  import ppu_seq_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BUF_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          cfg_count,
  input  logic [ADDR_W-1:0]         cfg_psum_base,
  input  logic [ADDR_W-1:0]         cfg_out_base,
  input  logic [SCALE_W-1:0]        cfg_scale,
  output logic                      busy,
  output logic                      done,
  output logic                      psum_rd_en,
  output logic [ADDR_W-1:0]         psum_rd_addr,
  input  logic [WORD_W-1:0]         psum_rd_data,
  output logic                      ppu_en,
  output logic [WORD_W-1:0]         ppu_data_in,
  output logic [SCALE_W-1:0]        ppu_scale,
  input  logic                      ppu_valid,
  input  logic [7:0]                ppu_data_out,
  output logic                      out_wr_en,
  input  logic                      out_wr_ready,
  output logic [ADDR_W-1:0]         out_wr_addr,
  output logic [WORD_W-1:0]         out_wr_data,
  output logic [BYTES_PER_WORD-1:0] out_wr_strb
`ifdef PPU_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_active_cyc,
  output logic [31:0]               perf_stall_cyc
`endif
);

  localparam int unsigned FCNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SUM_W  = FCNT_W + 1;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [ADDR_W-1:0]         psum_base_q, psum_base_d;
  logic [ADDR_W-1:0]         out_addr_q, out_addr_d;
  logic [SCALE_W-1:0]        scale_q, scale_d;
  logic [CNT_W-1:0]          issued_q, issued_d;
  logic [CNT_W-1:0]          popped_q, popped_d;
  logic [FCNT_W-1:0]         inflight_q, inflight_d;
  logic [WORD_W-1:0]         pack_data_q, pack_data_d;
  logic [2:0]                pack_cnt_q, pack_cnt_d;
  logic                      rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic                      ppu_en_q;
  logic                      out_en_q, out_en_d;
  logic [WORD_W-1:0]         out_data_q, out_data_d;
  logic [BYTES_PER_WORD-1:0] out_strb_q, out_strb_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic                      issue;
  logic                      word_rdy;
  logic                      out_free;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [7:0]                fifo_head;
  logic [FCNT_W-1:0]         fifo_cnt;

  // Late PPU results after an abort are dropped; only a running pass fills the FIFO.
  assign fifo_push = ppu_valid && (state_q == RUN || state_q == DRAIN);

  ppu_byte_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i (ppu_data_out),
    .pop_i       (fifo_pop),
    .head_c_o    (fifo_head),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    psum_base_d = psum_base_q;
    out_addr_d  = out_addr_q;
    scale_d     = scale_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    pack_data_d = pack_data_q;
    pack_cnt_d  = pack_cnt_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    out_en_d    = out_en_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    issue       = 1'b0;
    fifo_pop    = 1'b0;
    word_rdy    = (pack_cnt_q == 3'd4) || (pack_cnt_q != 3'd0 && popped_q == count_q);
    out_free    = !out_en_q || out_wr_ready;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d     = cfg_count;
          psum_base_d = cfg_psum_base;
          out_addr_d  = cfg_out_base;
          scale_d     = (cfg_scale == '0) ? SCALE_W'(1) : cfg_scale;
          issued_d    = '0;
          popped_d    = '0;
          state_d     = (cfg_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Reserve FIFO space for every read in flight so pushes can never overflow.
        if (issued_q != count_q &&
            (SUM_W'(fifo_cnt) + SUM_W'(inflight_q)) < SUM_W'(BUF_DEPTH)) begin
          issue = 1'b1;
          if (issued_q == count_q - CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0 && fifo_cnt == '0 && pack_cnt_q == 3'd0 && !out_en_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      rd_en_d   = 1'b1;
      rd_addr_d = psum_base_q + ADDR_W'(issued_q);
      issued_d  = issued_q + CNT_W'(1);
    end
    inflight_d = inflight_q + FCNT_W'(issue) - FCNT_W'(fifo_push);

    if (fifo_cnt != '0 && pack_cnt_q != 3'd4) begin
      fifo_pop    = 1'b1;
      pack_data_d = pack_data_q | (WORD_W'(fifo_head) << {pack_cnt_q[1:0], 3'b000});
      pack_cnt_d  = pack_cnt_q + 3'd1;
      popped_d    = popped_q + CNT_W'(1);
    end

    if (out_en_q && out_wr_ready) begin
      out_en_d   = 1'b0;
      out_addr_d = out_addr_q + ADDR_W'(1);
    end

    // A packed word only moves out once the output register is free or being accepted.
    if (word_rdy && out_free) begin
      out_en_d    = 1'b1;
      out_data_d  = pack_data_q;
      out_strb_d  = tail_strb(pack_cnt_q);
      pack_data_d = '0;
      pack_cnt_d  = 3'd0;
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      psum_base_q <= '0;
      out_addr_q  <= '0;
      scale_q     <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      inflight_q  <= '0;
      pack_data_q <= '0;
      pack_cnt_q  <= 3'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      ppu_en_q    <= 1'b0;
      out_en_q    <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      psum_base_q <= psum_base_d;
      out_addr_q  <= out_addr_d;
      scale_q     <= scale_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      inflight_q  <= inflight_d;
      pack_data_q <= pack_data_d;
      pack_cnt_q  <= pack_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      ppu_en_q    <= rd_en_q;
      out_en_q    <= out_en_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign psum_rd_en   = rd_en_q;
  assign psum_rd_addr = rd_addr_q;
  assign ppu_en       = ppu_en_q;
  // SRAM data arrives the cycle after the read, so it is forwarded straight to the PPU.
  assign ppu_data_in  = ppu_en_q ? psum_rd_data : '0;
  assign ppu_scale    = scale_q;
  assign out_wr_en    = out_en_q;
  assign out_wr_addr  = out_addr_q;
  assign out_wr_data  = out_data_q;
  assign out_wr_strb  = out_strb_q;

`ifdef PPU_SEQ_CTRL_PERF_EN
  logic [31:0] perf_active_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == IDLE && start)) begin
      perf_active_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (busy_q)                   perf_active_q <= perf_active_q + 32'd1;
      if (out_en_q && !out_wr_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_active_cyc = perf_active_q;
  assign perf_stall_cyc  = perf_stall_q;
`endif

endmodule
